// File: rtl/ce_divider_chain.sv
// ce_divider_chain: three-stage phase-aligned clock-enable generator (base / mid / slow) with run/restart control and a slow-tick counter.
// Latency: each ce_* output is registered, one clk after its terminal count; ce_mid and ce_slow only ever coincide with ce_base.
// Control: no backpressure. run=0 holds every divider, and restart clears the chain. Define CE_DIVIDER_FRAC_EN to swap the integer prescaler for a phase accumulator.
module ce_divider_chain #(
    parameter int unsigned      PRESCALE = 145,
    parameter int unsigned      MID_DIV  = 4096,
    parameter int unsigned      SLOW_DIV = 8,
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      ACC_W    = 24,
    parameter logic [ACC_W-1:0] FRAC_INC = 24'd116508
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic             clr_count,
    output logic             ce_base,
    output logic             ce_mid,
    output logic             ce_slow,
    output logic [CNT_W-1:0] tick_count,
    output logic             overflow
);

    // Divider widths: enough bits for 0..DIV-1, never narrower than one bit.
    localparam int unsigned MW = (MID_DIV  > 1) ? $clog2(MID_DIV)  : 1;
    localparam int unsigned SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    localparam logic [MW-1:0] M_LAST = MW'(MID_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SLOW_DIV - 1);

    // Reject configurations that cannot produce a sensible pulse train.
    if (PRESCALE < 2 || MID_DIV < 2 || SLOW_DIV < 2 || CNT_W < 1 || ACC_W < 1 || FRAC_INC == '0) begin : g_param_check
        $error("ce_divider_chain: divisors must be >= 2 and widths/increment non-zero");
    end

    logic          tick_base;
    logic          tick_mid;
    logic          tick_slow;
    logic [MW-1:0] m;
    logic [SW-1:0] s;

`ifdef CE_DIVIDER_FRAC_EN
    // Fractional prescaler: the carry out of the phase accumulator marks a base tick.
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum   = {1'b0, acc} + {1'b0, FRAC_INC};
    // A restart cancels a terminal count in the same cycle.
    assign tick_base = run & ~restart & acc_sum[ACC_W];

    // Phase accumulator advances by FRAC_INC each running clk; restart returns it to zero phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (restart) begin
            acc <= '0;
        end else if (run) begin
            acc <= acc_sum[ACC_W-1:0];
        end
    end
`else
    // Integer prescaler: p counts 0..PRESCALE-1 and the last value marks a base tick.
    localparam int unsigned   PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p;

    // A restart cancels a terminal count in the same cycle.
    assign tick_base = run & ~restart & (p == P_LAST);

    // Prescale counter: advances every running clk, wraps on its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (restart) begin
            p <= '0;
        end else if (tick_base) begin
            p <= '0;
        end else if (run) begin
            p <= p + PW'(1);
        end
    end
`endif

    // Slower ticks are qualified by the faster ones, which keeps all enables phase-aligned.
    assign tick_mid  = tick_base & (m == M_LAST);
    assign tick_slow = tick_mid  & (s == S_LAST);

    // Mid divider: counts base ticks, wraps on its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
        end else if (restart) begin
            m <= '0;
        end else if (tick_mid) begin
            m <= '0;
        end else if (tick_base) begin
            m <= m + MW'(1);
        end
    end

    // Slow divider: counts mid ticks, wraps on its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
        end else if (restart) begin
            s <= '0;
        end else if (tick_slow) begin
            s <= '0;
        end else if (tick_mid) begin
            s <= s + SW'(1);
        end
    end

    // Registered enables: one-cycle pulses the clk after each terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_base <= 1'b0;
            ce_mid  <= 1'b0;
            ce_slow <= 1'b0;
        end else begin
            ce_base <= tick_base;
            ce_mid  <= tick_mid;
            ce_slow <= tick_slow;
        end
    end

    // Slow-tick counter with sticky wrap flag; a clear wins over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_count <= '0;
            overflow   <= 1'b0;
        end else if (clr_count) begin
            tick_count <= '0;
            overflow   <= 1'b0;
        end else if (tick_slow) begin
            tick_count <= tick_count + CNT_W'(1);
            if (&tick_count) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ce_divider_chain.sv
// Testbench for ce_divider_chain with PRESCALE=4, MID_DIV=3, SLOW_DIV=2, CNT_W=2 (ACC_W=4, FRAC_INC=3 for the fractional build).
// Expected pulse cycles are queued when stimulus is applied and consumed as the DUT pulses; counter values are checked at directed points.
// Cycle k means the state visible just after the k-th rising edge following reset release.
module tb_ce_divider_chain;

    localparam int TB_INC = 3;
    localparam int TB_MOD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       restart;
    logic       clr_count;
    logic       ce_base;
    logic       ce_mid;
    logic       ce_slow;
    logic [1:0] tick_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int q_base[$];
    int q_mid[$];
    int q_slow[$];

    int exp_tc[5];
    int exp_ov[5];

    always #5 clk = ~clk;

    ce_divider_chain #(
        .PRESCALE (4),
        .MID_DIV  (3),
        .SLOW_DIV (2),
        .CNT_W    (2),
        .ACC_W    (4),
        .FRAC_INC (4'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .restart    (restart),
        .clr_count  (clr_count),
        .ce_base    (ce_base),
        .ce_mid     (ce_mid),
        .ce_slow    (ce_slow),
        .tick_count (tick_count),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
        end
    endtask

    // Advance one clock, then compare each enable against the head of its scoreboard queue.
    task automatic cyc();
        logic eb;
        logic em;
        logic es;
        @(posedge clk);
        #1;
        cycle++;
        eb = (q_base.size() != 0) && (q_base[0] == cycle);
        em = (q_mid.size()  != 0) && (q_mid[0]  == cycle);
        es = (q_slow.size() != 0) && (q_slow[0] == cycle);
        chk("ce_base", {31'd0, ce_base}, {31'd0, eb});
        chk("ce_mid",  {31'd0, ce_mid},  {31'd0, em});
        chk("ce_slow", {31'd0, ce_slow}, {31'd0, es});
        if (eb) void'(q_base.pop_front());
        if (em) void'(q_mid.pop_front());
        if (es) void'(q_slow.pop_front());
    endtask

    task automatic end_phase(input string tag);
        chk({tag, "_base_left"}, q_base.size(), 0);
        chk({tag, "_mid_left"},  q_mid.size(),  0);
        chk({tag, "_slow_left"}, q_slow.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ce_base"},    {31'd0, ce_base},    0);
        chk({tag, "_ce_mid"},     {31'd0, ce_mid},     0);
        chk({tag, "_ce_slow"},    {31'd0, ce_slow},    0);
        chk({tag, "_tick_count"}, {30'd0, tick_count}, 0);
        chk({tag, "_overflow"},   {31'd0, overflow},   0);
    endtask

    // Hold reset for a few clocks with run=1, check the reset state, then release between edges.
    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b1;
        restart   = 1'b0;
        clr_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        q_base.delete();
        q_mid.delete();
        q_slow.delete();
        rst   = 1'b0;
        cycle = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        restart   = 1'b0;
        clr_count = 1'b0;
        exp_tc    = '{1, 2, 3, 0, 0};
        exp_ov    = '{0, 0, 0, 1, 0};

`ifdef CE_DIVIDER_FRAC_EN
        // Fractional prescaler: base pulse whenever 3*k crosses a multiple of 16.
        begin
            int nb;
            nb = 0;
            do_reset();
            for (int k = 1; k <= 64; k++) begin
                if ((TB_INC * k) / TB_MOD != (TB_INC * (k - 1)) / TB_MOD) begin
                    nb++;
                    q_base.push_back(k);
                    if (nb % 3 == 0) q_mid.push_back(k);
                    if (nb % 6 == 0) q_slow.push_back(k);
                end
            end
            chk("frac_pulses_in_64", q_base.size(), 12);
            repeat (64) cyc();
            end_phase("frac");
        end
`else
        // Free run: base every 4, mid every 12, slow every 24.
        do_reset();
        for (int c = 4; c <= 48; c += 4) q_base.push_back(c);
        for (int c = 12; c <= 48; c += 12) q_mid.push_back(c);
        q_slow.push_back(24);
        q_slow.push_back(48);
        repeat (48) cyc();
        end_phase("free");
        chk("free_tick_count", {30'd0, tick_count}, 2);
        chk("free_overflow",   {31'd0, overflow},   0);

        // run low for edges 10..14: counters hold, pulses resume 5 clks late.
        do_reset();
        q_base = '{4, 8, 17, 21, 25, 29};
        q_mid  = '{17, 29};
        q_slow = '{29};
        repeat (9) cyc();
        run = 1'b0;
        repeat (5) cyc();
        run = 1'b1;
        repeat (16) cyc();
        end_phase("hold");
        chk("hold_tick_count", {30'd0, tick_count}, 1);

        // restart sampled at edge 11 (p=2, m=2): chain starts over.
        do_reset();
        q_base = '{4, 8, 15, 19, 23};
        q_mid  = '{23};
        repeat (10) cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        repeat (13) cyc();
        end_phase("restart");

        // tick_count wrap, sticky overflow, and clear coincident with the 5th slow tick.
        do_reset();
        for (int c = 4; c <= 120; c += 4) q_base.push_back(c);
        for (int c = 12; c <= 120; c += 12) q_mid.push_back(c);
        for (int c = 24; c <= 120; c += 24) q_slow.push_back(c);
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) begin
                repeat (24) cyc();
            end else begin
                repeat (23) cyc();
                chk("ovf_sticky", {31'd0, overflow}, 1);
                chk("tc_before_clr", {30'd0, tick_count}, 0);
                clr_count = 1'b1;
                cyc();
                clr_count = 1'b0;
            end
            chk("tick_count", {30'd0, tick_count}, exp_tc[k-1]);
            chk("overflow",   {31'd0, overflow},   exp_ov[k-1]);
        end
        end_phase("count");

        // Asynchronous reset while all three enables are high.
        do_reset();
        for (int c = 4; c <= 48; c += 4) q_base.push_back(c);
        for (int c = 12; c <= 48; c += 12) q_mid.push_back(c);
        q_slow.push_back(24);
        q_slow.push_back(48);
        repeat (48) cyc();
        end_phase("pre_async");
        chk("pre_async_tick_count", {30'd0, tick_count}, 2);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async");
        @(posedge clk);
        #4;
        rst   = 1'b0;
        cycle = 0;
        q_base = '{4, 8};
        repeat (8) cyc();
        end_phase("post_async");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
